nibble_xform_decoder: RTL and testbench

NIBBLE_XFORM_DECODER -- requirements
Module: nibble_xform_decoder

---
 rtl/nibble_xform_decoder_pkg.sv | 39 +++
 rtl/nibble_xform_decoder_fifo.sv | 70 +++++++
 rtl/nibble_xform_decoder.sv | 115 +++++++++++
 tb/tb_nibble_xform_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_xform_decoder_pkg.sv
// Shared decode definitions for the nibble transform decoder.
// The decode result is carried at a fixed maximum width so the same
// function serves any WIDTH below XF_MAX_W; callers keep the low bits.
package nibble_xform_decoder_pkg;

  localparam int XF_MAX_W = 32;

  typedef struct packed {
    logic [XF_MAX_W-1:0] data;
    logic                amb;
    logic                err;
  } xf_res_t;

  // Invert the forward transform (odd codes: +1, even codes: << shift).
  // Bits above 'width' in the result are always zero.
  function automatic xf_res_t xf_decode(input logic [XF_MAX_W-1:0] code,
                                        input int                  width,
                                        input int                  shift);
    xf_res_t             r;
    logic [XF_MAX_W-1:0] mask;
    logic [XF_MAX_W-1:0] sh;
    mask = {XF_MAX_W{1'b1}} >> (XF_MAX_W - width);
    sh   = (code & mask) >> shift;
    r    = '0;
    if (code[0]) begin
      r.data = (code - XF_MAX_W'(1)) & mask;
      r.amb  = 1'b0;
      r.err  = 1'b0;
    end else begin
      // The forward shift always produces odd data, so an even recovery
      // means the code could never have come out of the transform.
      r.data = sh & mask;
      r.amb  = 1'b1;
      r.err  = ~sh[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_xform_decoder_fifo.sv
// Small synchronous FIFO with registered occupancy. Full/empty are pure
// functions of the occupancy register, so the write side never sees a
// combinational path from the read handshake. The head word reads as zero
// while empty so the outputs come up clean out of reset.
module sync_fifo_small #(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr, rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign wr        = wr_en_i && !full_o;
  assign rd        = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; simultaneous push and pop cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the queue regardless of stored words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents only matter once counted as occupied.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/nibble_xform_decoder.sv
// Decoder for the increment/shift forward transform. Each accepted code is
// decoded combinationally and queued as {data, amb, err}; saturating
// statistics count accepted, ambiguous and illegal codes.
module nibble_xform_decoder
  import nibble_xform_decoder_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SHIFT_VALUE = 1,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_amb,
  output logic             out_err,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_amb,
  output logic [CNT_W-1:0] cnt_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             amb;
    logic             err;
  } entry_t;

  localparam int EW = $bits(entry_t);

  xf_res_t                   dec;
  logic [XF_MAX_W-1:WIDTH]   dec_hi_unused;
  entry_t                    wr_ent, rd_ent;
  logic [EW-1:0]             rd_raw;
  logic                      fifo_full, fifo_empty;
  logic                      acc;
  logic [CNT_W-1:0]          words_q, words_d;
  logic [CNT_W-1:0]          amb_q, amb_d;
  logic [CNT_W-1:0]          err_q, err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Decode the incoming code; bits above WIDTH are zero by construction.
  always_comb begin
    dec           = xf_decode(XF_MAX_W'(in_code), WIDTH, SHIFT_VALUE);
    dec_hi_unused = dec.data[XF_MAX_W-1:WIDTH];
    wr_ent.data   = dec.data[WIDTH-1:0];
    wr_ent.amb    = dec.amb;
    wr_ent.err    = dec.err;
  end

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign acc       = in_valid && in_ready;
  assign rd_ent    = entry_t'(rd_raw);
  assign out_data  = rd_ent.data;
  assign out_amb   = rd_ent.amb;
  assign out_err   = rd_ent.err;

  sync_fifo_small #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_valid),
    .wr_data_i (wr_ent),
    .rd_en_i   (out_ready),
    .rd_data_o (rd_raw),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Statistics next state; clear wins over a same-cycle accept.
  always_comb begin
    words_d = words_q;
    amb_d   = amb_q;
    err_d   = err_q;
    if (clear) begin
      words_d = '0;
      amb_d   = '0;
      err_d   = '0;
    end else if (acc) begin
      words_d = sat_inc(words_q, 1'b1);
      amb_d   = sat_inc(amb_q, wr_ent.amb);
      err_d   = sat_inc(err_q, wr_ent.err);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      amb_q   <= '0;
      err_q   <= '0;
    end else begin
      words_q <= words_d;
      amb_q   <= amb_d;
      err_q   <= err_d;
    end
  end

  assign cnt_words = words_q;
  assign cnt_amb   = amb_q;
  assign cnt_err   = err_q;

endmodule

// File: tb/tb_nibble_xform_decoder.sv
// Scoreboard bench: the negedge monitor compares the FIFO head and counters
// against a queue/counter model fed from observed handshakes.
module tb_nibble_xform_decoder;

  localparam int W  = 4;
  localparam int SH = 1;
  localparam int D  = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct { int data; int amb; int err; } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  in_code = '0;
  logic          in_ready, out_valid, out_amb, out_err;
  logic [W-1:0]  out_data;
  logic [CW-1:0] cnt_words, cnt_amb, cnt_err;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   m_words = 0, m_amb = 0, m_err = 0;

  always #5 clk = ~clk;

  nibble_xform_decoder #(
    .WIDTH(W), .SHIFT_VALUE(SH), .DEPTH(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_amb(out_amb), .out_err(out_err),
    .clear(clear),
    .cnt_words(cnt_words), .cnt_amb(cnt_amb), .cnt_err(cnt_err)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode straight from the transform rules, in plain integers.
  function automatic exp_t model(input int code);
    exp_t r;
    if (code % 2 == 1) begin
      r.data = (code + (1 << W) - 1) % (1 << W);
      r.amb  = 0;
      r.err  = 0;
    end else begin
      r.data = code / (1 << SH);
      r.amb  = 1;
      r.err  = (r.data % 2 == 0) ? 1 : 0;
    end
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Monitor: check state left by the last edge, then account for the next.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      m_words = 0; m_amb = 0; m_err = 0;
    end else begin
      chk("out_valid", int'(out_valid), (exp_q.size() != 0) ? 1 : 0);
      chk("in_ready", int'(in_ready), (exp_q.size() < D) ? 1 : 0);
      if (out_valid && exp_q.size() != 0) begin
        chk("out_data", int'(out_data), exp_q[0].data);
        chk("out_amb", int'(out_amb), exp_q[0].amb);
        chk("out_err", int'(out_err), exp_q[0].err);
      end
      chk("cnt_words", int'(cnt_words), m_words);
      chk("cnt_amb", int'(cnt_amb), m_amb);
      chk("cnt_err", int'(cnt_err), m_err);
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        e = model(int'(in_code));
        exp_q.push_back(e);
      end
      if (clear) begin
        m_words = 0; m_amb = 0; m_err = 0;
      end else if (in_valid && in_ready) begin
        m_words = sat(m_words);
        if (e.amb != 0) m_amb = sat(m_amb);
        if (e.err != 0) m_err = sat(m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_code  = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] codes [5];
    codes = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9};

    // Reset values while held, then ready right after release
    repeat (2) step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_cnt_words", int'(cnt_words), 0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", int'(in_ready), 1);

    // Single-word decodes with latency-1 visibility
    out_ready = 1'b1;
    push(4'b0011);
    chk("inc_valid", int'(out_valid), 1);
    chk("inc_data", int'(out_data), 2);
    chk("inc_amb", int'(out_amb), 0);
    chk("inc_words", int'(cnt_words), 1);
    step();
    push(4'b1010);
    chk("shift_data", int'(out_data), 5);
    chk("shift_amb", int'(out_amb), 1);
    chk("shift_err", int'(out_err), 0);
    chk("shift_cnt_amb", int'(cnt_amb), 1);
    step();
    push(4'b0000);
    chk("illegal_data", int'(out_data), 0);
    chk("illegal_err", int'(out_err), 1);
    chk("illegal_cnt_err", int'(cnt_err), 1);
    step();

    // Backpressure: two accepts fill the FIFO, third waits
    out_ready = 1'b0;
    push(4'h3);
    push(4'h5);
    in_valid = 1'b1;
    in_code  = 4'h7;
    step();
    step();
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_hold_data", int'(out_data), 2);
    out_ready = 1'b1;
    push(4'h7);
    repeat (4) step();

    // Saturation and clear priority
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) push(codes[i]);
    step();
    chk("sat_words", int'(cnt_words), CMAX);
    chk("pre_clear_ready", int'(in_ready), 1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_code  = 4'hB;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_prio_words", int'(cnt_words), 0);
    repeat (3) step();

    // Asynchronous reset with a full FIFO
    out_ready = 1'b0;
    push(4'h1);
    push(4'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_cnt_words", int'(cnt_words), 0);
    chk("arst_cnt_amb", int'(cnt_amb), 0);
    chk("arst_cnt_err", int'(cnt_err), 0);
    step();
    step();
    rst = 1'b0;
    chk("arst_in_ready", int'(in_ready), 1);
    step();
    chk("arst_no_stale", int'(out_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_code   = W'($urandom);
      out_ready = ($urandom % 4) != 0;
      clear     = ($urandom % 16) == 0;
      step();
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
